iir_mac_sequencer: RTL and testbench
====================================

Name: iir_mac_sequencer

Overview:
- Sequences one shared fixed-point multiplier (Q12.16 operands carried in 57-bit signed words; the product is divided by 2^16) through the five taps of a direct-form-I biquad, one tap per cycle.
- Holds the coefficient bank, the x/y history, the accumulator and the input/output stream handshakes.
- Sits between the sample stream and output stream of the FilterIIR IP; the multiplier is instantiated outside this block and driven through the mult_* ports.

Parameters:
- FRAC_BITS, 16, fractional bits; product scaling is divide by 2^FRAC_BITS.
- INT_BITS, 12, integer bits of a sample/coefficient.
- DATA_W, 2*(FRAC_BITS+INT_BITS)+1 = 57, width of every data word, multiplier operand and accumulator.

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  signed sample x[n].
- in_valid  in  1  sample offered.
- in_ready  out  1  block accepts a sample.
- out_data  out  DATA_W  signed y[n].
- out_valid  out  1  y[n] available.
- out_ready  in  1  consumer accepts y[n].
- coef_wr_en  in  1  coefficient write request.
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
- coef_data  in  DATA_W  signed coefficient; a-terms are stored pre-negated by software.
- coef_wr_ready  out  1  write accepted this cycle.
- hist_clr  in  1  pulse: zero x1, x2, y1, y2.
- mult_a  out  DATA_W  multiplier operand (coefficient).
- mult_b  out  DATA_W  multiplier operand (history/sample).
- mult_p  in  DATA_W  combinational product from the shared multiplier, same cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Filter equation: y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2. Each term is mult_p = trunc-toward-zero((a*b)/2^16), truncated to DATA_W. Accumulation wraps modulo 2^DATA_W, with no saturation.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch x = in_data, clear acc, go to MAC with tap=0.
  - MAC: tap counts 0..4, one term per cycle. mult_a/mult_b are driven from registers selected by tap (0:b0/x, 1:b1/x1, 2:b2/x2, 3:a1/y1, 4:a2/y2), and acc += mult_p at the clock edge. At tap=4, register out_data = acc + mult_p, update history (x2<=x1, x1<=x, y2<=y1, y1<=new y), go to OUT.
  - OUT: out_valid=1 with out_data held stable. On out_ready, return to IDLE.
- Latency: sample accepted at edge T; taps run at edges T+1..T+5; out_valid is high from T+5 until the handshake. Throughput is one sample per 7 cycles when out_ready=1.
- mult_a and mult_b are 0 outside MAC.
- Coefficient writes: coef_wr_ready = (state==IDLE). A write occurs on the edge where coef_wr_en && coef_wr_ready. If a write and in_valid arrive in the same IDLE cycle, both are taken and the new coefficient is used for that sample.
- hist_clr:
  - In IDLE: applied at the next edge.
  - Otherwise: latched into clr_pending and applied on the edge that returns to IDLE. It overrides that cycle's history update.
  - While clr_pending=1: in_ready=0.
- Reset (aresetn low, asynchronous, including mid-MAC or mid-OUT):
  - State goes to IDLE, and tap, acc, x, x1, x2, y1, y2, all coefficients, out_data and clr_pending go to 0.
  - Reset values of the outputs: out_valid=0, busy=0, in_ready=1, coef_wr_ready=1.
  - Any in-flight result is discarded.
- in_valid outside IDLE is ignored and does not stall. out_ready outside OUT is ignored.

Test Plan:
- Pass-through: b0=0x10000 (1.0), others 0; x=0x28000 (2.5) at edge T -> out_valid rises after edge T+5, out_data=0x28000; mult_a/mult_b are 0 outside MAC.
- Recursion: b0=0x10000, a1=0x08000 (0.5); inputs 0x10000, 0, 0 with out_ready=1 -> outputs 0x10000, 0x08000, 0x04000; a second sample offered during MAC waits, and in_ready stays 0.
- Sign and truncation: b0 = -0x10000, x=0x18000 -> out_data = -0x18000 (sign-extended 57-bit). Then b0=0x1, x=-0x1 -> out_data=0 (truncation toward zero, not -1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, busy=1, in_ready=0, coef_wr_ready=0. A coefficient write held during this time completes on the first IDLE cycle.
- hist_clr mid-MAC: prime y1=0x10000 with a1=0x10000, pulse hist_clr during tap 2 -> the current y completes normally. The next sample x=0 gives out_data=0, and in_ready stays 0 until the clear is applied.
- Reset mid-MAC: assert aresetn low during tap 3 -> out_valid and busy drop immediately with no output. After release, with b0 rewritten to 0x10000 and x=0x10000 -> out_data=0x10000 (history and other coefficients are zero).

Source files
------------

// File: rtl/iir_mac_sequencer.sv
// Biquad MAC sequencer: drives one shared external multiplier through five DF-I taps per sample.
// Latency: sample accepted at edge T, taps at T+1..T+5, out_valid from T+5 until taken.
// Backpressure: in_ready and coef_wr_ready drop outside IDLE; out_ready low holds OUT indefinitely.
module iir_mac_sequencer #(
    parameter int FRAC_BITS = 16,
    parameter int INT_BITS  = 12,
    parameter int DATA_W    = 2*(FRAC_BITS+INT_BITS)+1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_wr_en,
    input  logic [2:0]               coef_addr,
    input  logic signed [DATA_W-1:0] coef_data,
    output logic                     coef_wr_ready,
    input  logic                     hist_clr,
    output logic signed [DATA_W-1:0] mult_a,
    output logic signed [DATA_W-1:0] mult_b,
    input  logic signed [DATA_W-1:0] mult_p,
    output logic                     busy
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_tap;
    logic signed [DATA_W-1:0]  r_acc;
    logic signed [DATA_W-1:0]  r_x, r_x1, r_x2, r_y1, r_y2;
    logic signed [DATA_W-1:0]  r_out_data;
    logic signed [DATA_W-1:0]  r_coef [5];
    logic                      r_clr_pending;

    logic                      w_accept;
    logic                      w_coef_wr;
    logic                      w_last_tap;
    logic                      w_to_idle;
    logic                      w_hist_zero;
    logic signed [DATA_W-1:0]  w_y;

    assign w_accept    = in_ready && in_valid;
    assign w_coef_wr   = coef_wr_en && coef_wr_ready;
    assign w_last_tap  = (r_state == S_MAC) && (r_tap == 3'd4);
    assign w_to_idle   = (r_state == S_OUT) && out_ready;
    assign w_y         = r_acc + mult_p;
    // A clear arriving on the very edge that returns to IDLE is applied immediately.
    assign w_hist_zero = ((r_state == S_IDLE) && hist_clr) ||
                         (w_to_idle && (r_clr_pending || hist_clr));
    assign out_data    = r_out_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        coef_wr_ready = 1'b0;
        busy          = 1'b1;
        mult_a        = '0;
        mult_b        = '0;
        case (r_state)
            S_IDLE: begin
                busy          = 1'b0;
                coef_wr_ready = 1'b1;
                in_ready      = !r_clr_pending;
                if (in_valid && !r_clr_pending) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                case (r_tap)
                    3'd0:    begin mult_a = r_coef[0]; mult_b = r_x;  end
                    3'd1:    begin mult_a = r_coef[1]; mult_b = r_x1; end
                    3'd2:    begin mult_a = r_coef[2]; mult_b = r_x2; end
                    3'd3:    begin mult_a = r_coef[3]; mult_b = r_y1; end
                    default: begin mult_a = r_coef[4]; mult_b = r_y2; end
                endcase
                if (r_tap == 3'd4) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tap         <= '0;
            r_acc         <= '0;
            r_x           <= '0;
            r_x1          <= '0;
            r_x2          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_out_data    <= '0;
            r_clr_pending <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            if (w_coef_wr && (coef_addr < 3'd5)) begin
                r_coef[coef_addr] <= coef_data;
            end

            if (w_accept) begin
                r_x   <= in_data;
                r_acc <= '0;
                r_tap <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_y;
                r_tap <= r_tap + 3'd1;
            end

            if (w_last_tap) begin
                r_out_data <= w_y;
                r_x2       <= r_x1;
                r_x1       <= r_x;
                r_y2       <= r_y1;
                r_y1       <= w_y;
            end

            if (hist_clr && (r_state != S_IDLE) && !w_to_idle) begin
                r_clr_pending <= 1'b1;
            end else if (w_to_idle) begin
                r_clr_pending <= 1'b0;
            end

            // Placed last so a clear wins over the history shift.
            if (w_hist_zero) begin
                r_x1 <= '0;
                r_x2 <= '0;
                r_y1 <= '0;
                r_y2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Bench for iir_mac_sequencer: models the external multiplier, runs a vector table
// through a scoreboard queue, then hand-written timing, backpressure, clear and reset sequences.
module tb_iir_mac_sequencer;

    localparam int DW = 57;
    typedef logic signed [DW-1:0] word_t;

    typedef struct {
        bit    clr;
        word_t b0, b1, b2, a1, a2;
        word_t x;
        word_t exp_y;
    } vec_t;

    logic        aclk;
    logic        aresetn;
    word_t       in_data;
    logic        in_valid;
    logic        in_ready;
    word_t       out_data;
    logic        out_valid;
    logic        out_ready;
    logic        coef_wr_en;
    logic [2:0]  coef_addr;
    word_t       coef_data;
    logic        coef_wr_ready;
    logic        hist_clr;
    word_t       mult_a;
    word_t       mult_b;
    word_t       mult_p;
    logic        busy;

    // Shared multiplier: full product, divided by 2^16 truncating toward zero.
    localparam logic signed [2*DW-1:0] DIV = 114'sd65536;
    logic signed [2*DW-1:0] w_full;
    logic signed [2*DW-1:0] w_q;
    assign w_full = mult_a * mult_b;
    assign w_q    = w_full / DIV;
    assign mult_p = w_q[DW-1:0];

    iir_mac_sequencer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .coef_wr_en    (coef_wr_en),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .coef_wr_ready (coef_wr_ready),
        .hist_clr      (hist_clr),
        .mult_a        (mult_a),
        .mult_b        (mult_b),
        .mult_p        (mult_p),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    vec_t  vecs [9];
    word_t sb_q [$];
    int    n_vec;
    int    n_err;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input word_t d);
        logic done;
        done       = 1'b0;
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        for (int i = 0; i < 30 && !done; i++) begin
            if (coef_wr_ready) done = 1'b1;
            tick();
        end
        coef_wr_en = 1'b0;
        if (!done) check_bit("coef_wr_accept", done, 1'b1);
    endtask

    task automatic write_all(input word_t b0, input word_t b1, input word_t b2,
                             input word_t a1, input word_t a2);
        write_coef(3'd0, b0);
        write_coef(3'd1, b1);
        write_coef(3'd2, b2);
        write_coef(3'd3, a1);
        write_coef(3'd4, a2);
    endtask

    task automatic pulse_clr();
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
    endtask

    task automatic send(input word_t x, input word_t exp_y);
        logic rdy;
        rdy = 1'b0;
        for (int i = 0; i < 30 && !rdy; i++) begin
            if (in_ready) rdy = 1'b1;
            else tick();
        end
        if (!rdy) check_bit("send_in_ready", rdy, 1'b1);
        in_valid = 1'b1;
        in_data  = x;
        sb_q.push_back(exp_y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check_bit({name, "_vld"}, seen, 1'b1);
    endtask

    task automatic collect(input string name);
        word_t exp_y;
        wait_valid(name);
        exp_y = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check(name, out_data, exp_y);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        //        clr   b0             b1            b2            a1             a2            x              y
        vecs[0] = '{1'b1, 57'sh10000,  57'sh0,       57'sh0,       57'sh0,        57'sh0,       57'sh28000,    57'sh28000};
        vecs[1] = '{1'b1, 57'sh10000,  57'sh0,       57'sh0,       57'sh08000,    57'sh0,       57'sh10000,    57'sh10000};
        vecs[2] = '{1'b0, 57'sh10000,  57'sh0,       57'sh0,       57'sh08000,    57'sh0,       57'sh0,        57'sh08000};
        vecs[3] = '{1'b0, 57'sh10000,  57'sh0,       57'sh0,       57'sh08000,    57'sh0,       57'sh0,        57'sh04000};
        vecs[4] = '{1'b1, -57'sh10000, 57'sh0,       57'sh0,       57'sh0,        57'sh0,       57'sh18000,    -57'sh18000};
        vecs[5] = '{1'b1, 57'sh1,      57'sh0,       57'sh0,       57'sh0,        57'sh0,       -57'sh1,       57'sh0};
        vecs[6] = '{1'b1, 57'sh10000,  57'sh20000,   57'sh08000,   -57'sh04000,   57'sh01000,   57'sh10000,    57'sh10000};
        vecs[7] = '{1'b0, 57'sh10000,  57'sh20000,   57'sh08000,   -57'sh04000,   57'sh01000,   57'sh20000,    57'sh3C000};
        vecs[8] = '{1'b0, 57'sh10000,  57'sh20000,   57'sh08000,   -57'sh04000,   57'sh01000,   -57'sh30000,   57'sh0A000};

        aresetn    = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        coef_wr_en = 1'b0;
        coef_addr  = '0;
        coef_data  = '0;
        hist_clr   = 1'b0;
        repeat (3) tick();

        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_coef_wr_ready", coef_wr_ready, 1'b1);
        check("rst_out_data", out_data, '0);
        check("rst_mult_a", mult_a, '0);
        aresetn = 1'b1;
        tick();

        // Pass-through timing: one sample, a second one offered during MAC must be ignored.
        write_all(57'sh10000, 57'sh0, 57'sh0, 57'sh0, 57'sh0);
        pulse_clr();
        check("idle_mult_b", mult_b, '0);
        in_valid = 1'b1;
        in_data  = 57'sh28000;
        tick();
        in_data  = 57'sh77777;
        check("tap0_mult_a", mult_a, 57'sh10000);
        check("tap0_mult_b", mult_b, 57'sh28000);
        check_bit("mac_busy", busy, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_bit("mac_out_valid_early", out_valid, 1'b0);
            check_bit("mac_in_ready", in_ready, 1'b0);
        end
        tick();
        in_valid = 1'b0;
        check_bit("lat_out_valid", out_valid, 1'b1);
        check("lat_out_data", out_data, 57'sh28000);
        check("out_mult_a", mult_a, '0);
        check("out_mult_b", mult_b, '0);
        tick();
        check_bit("post_busy", busy, 1'b0);
        check_bit("post_out_valid", out_valid, 1'b0);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].clr) pulse_clr();
            write_all(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].a1, vecs[v].a2);
            send(vecs[v].x, vecs[v].exp_y);
            collect($sformatf("vec%0d", v));
        end

        // Backpressure with a coefficient write held across the stall.
        pulse_clr();
        write_all(57'sh10000, 57'sh0, 57'sh0, 57'sh0, 57'sh0);
        out_ready = 1'b0;
        send(57'sh10000, 57'sh10000);
        wait_valid("bp_first");
        coef_wr_en = 1'b1;
        coef_addr  = 3'd1;
        coef_data  = 57'sh30000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_out_data", out_data, 57'sh10000);
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_bit("bp_busy", busy, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_coef_wr_ready", coef_wr_ready, 1'b0);
        end
        collect("bp_result");
        check_bit("bp_idle_wr_ready", coef_wr_ready, 1'b1);
        tick();
        coef_wr_en = 1'b0;
        send(57'sh0, 57'sh30000);
        collect("bp_held_write");

        // Coefficient write and sample in the same IDLE cycle.
        pulse_clr();
        write_all(57'sh0, 57'sh0, 57'sh0, 57'sh0, 57'sh0);
        coef_wr_en = 1'b1;
        coef_addr  = 3'd0;
        coef_data  = 57'sh20000;
        in_valid   = 1'b1;
        in_data    = 57'sh10000;
        sb_q.push_back(57'sh20000);
        tick();
        coef_wr_en = 1'b0;
        in_valid   = 1'b0;
        collect("wr_and_sample");

        // hist_clr during tap 2: current result unaffected, history zero afterwards.
        pulse_clr();
        write_all(57'sh10000, 57'sh0, 57'sh0, 57'sh10000, 57'sh0);
        send(57'sh10000, 57'sh10000);
        collect("hc_prime");
        send(57'sh10000, 57'sh20000);
        tick();
        tick();
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        check_bit("hc_in_ready_mac", in_ready, 1'b0);
        collect("hc_current_y");
        check_bit("hc_in_ready_idle", in_ready, 1'b1);
        send(57'sh0, 57'sh0);
        collect("hc_next_zero");

        // Asynchronous reset during tap 3 discards the result and all state.
        write_all(57'sh20000, 57'sh10000, 57'sh0, 57'sh10000, 57'sh0);
        in_valid = 1'b1;
        in_data  = 57'sh10000;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("rst_mid_mult_a", mult_a, 57'sh10000);
        aresetn = 1'b0;
        #1;
        check_bit("rst_mid_out_valid", out_valid, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_in_ready", in_ready, 1'b1);
        check_bit("rst_mid_coef_wr_ready", coef_wr_ready, 1'b1);
        check("rst_mid_out_data", out_data, '0);
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        check_bit("rst_after_out_valid", out_valid, 1'b0);
        write_coef(3'd0, 57'sh10000);
        send(57'sh10000, 57'sh10000);
        collect("rst_after");

        check("sb_empty", word_t'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
